// File: rtl/ex_stage_pipe.sv
// RV32IM execute stage: ALU, branch/jump resolution with IF redirect, iterative MUL/DIV unit,
// and the registered EX/MEM output. ALU op codes are defined by the alu module below.

// alu op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
module alu #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    always_comb begin
        shamt = b[SH_W-1:0];
        lt_s  = $signed(a) < $signed(b);
        lt_u  = a < b;
        y     = '0;
        case (op)
            5'd0:    y = a + b;
            5'd1:    y = a - b;
            5'd2:    y = a << shamt;
            5'd3:    y = {{(XLEN-1){1'b0}}, lt_s};
            5'd4:    y = {{(XLEN-1){1'b0}}, lt_u};
            5'd5:    y = a ^ b;
            5'd6:    y = a >> shamt;
            5'd7:    y = $signed(a) >>> shamt;
            5'd8:    y = a | b;
            5'd9:    y = a & b;
            5'd10:   y = b;
            default: y = '0;
        endcase
    end
endmodule

// MDU sequencer states
//   state   | meaning
//   MD_IDLE | no divide/multiply in flight; accepts a new MDU op
//   MD_BUSY | one radix-2 step per cycle, XLEN steps total
//   MD_DONE | result valid; loads EX/MEM on the next unfrozen edge
module ex_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int MDU_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_de,
    input  logic [XLEN-1:0] pc_de,
    input  logic            alusrc_de,
    input  logic [4:0]      aluop_de,
    input  logic            rs1_pc_de,
    input  logic            rs1_z_de,
    input  logic            branch_de,
    input  logic            jal_de,
    input  logic            jalr_de,
    input  logic [2:0]      funct3_de,
    input  logic            md_op_de,
    input  logic [4:0]      rd_de,
    input  logic [XLEN-1:0] rf_data1_de,
    input  logic [XLEN-1:0] rf_data2_de,
    input  logic [XLEN-1:0] imm_de,
    input  logic            hold_m,
    output logic            stall_e,
    output logic            redirect_e,
    output logic [XLEN-1:0] redirect_pc_e,
    output logic            valid_em,
    output logic [XLEN-1:0] result_em,
    output logic [XLEN-1:0] rs2_em,
    output logic [4:0]      rd_em
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t md_state, md_state_nxt;

    logic [XLEN-1:0] op_a, op_b, alu_y;
    logic [XLEN-1:0] pc_imm, jalr_sum, link_pc;
    logic            br_eq, br_lt, br_ltu, br_cond, br_taken;
    logic            md_req, md_stall, md_start, md_step;

    logic [CNT_W-1:0] md_cnt;
    logic [2:0]       md_f3;
    logic             md_sa, md_sb, md_dz;
    logic [4:0]       md_rd;
    logic [XLEN-1:0]  md_opnd, acc_hi, acc_lo;

    logic             st_is_mul, st_sa, st_sb;
    logic [XLEN-1:0]  st_mag_a, st_mag_b;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]  quo_s, rem_s, md_result;

    always_comb begin
        op_a = rs1_pc_de ? pc_de : (rs1_z_de ? '0 : rf_data1_de);
        op_b = alusrc_de ? imm_de : rf_data2_de;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .op (aluop_de),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    always_comb begin
        br_eq   = rf_data1_de == rf_data2_de;
        br_lt   = $signed(rf_data1_de) < $signed(rf_data2_de);
        br_ltu  = rf_data1_de < rf_data2_de;
        br_cond = 1'b0;
        case (funct3_de)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = ~br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = ~br_lt;
            3'b110:  br_cond = br_ltu;
            3'b111:  br_cond = ~br_ltu;
            default: br_cond = 1'b0;
        endcase
        br_taken = branch_de & br_cond;
    end

    always_comb begin
        pc_imm        = pc_de + imm_de;
        jalr_sum      = rf_data1_de + imm_de;
        link_pc       = pc_de + XLEN'(4);
        redirect_pc_e = jalr_de ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;
    end

    // The stall holds ID/EX stable for the whole operation, so rd/funct3 stay visible,
    // but operands are latched anyway so the MDU never depends on upstream behaviour.
    always_comb begin
        md_req     = (MDU_EN != 0) && valid_de && md_op_de;
        md_stall   = md_req && (md_state != MD_DONE);
        stall_e    = rst_n & (md_stall | hold_m);
        redirect_e = rst_n & valid_de & ~stall_e & ~hold_m & (br_taken | jal_de | jalr_de);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) md_state <= MD_IDLE;
        else        md_state <= md_state_nxt;
    end

    always_comb begin
        md_state_nxt = md_state;
        md_start     = 1'b0;
        md_step      = 1'b0;
        case (md_state)
            MD_IDLE: begin
                if (md_req && !hold_m) begin
                    md_start     = 1'b1;
                    md_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (!hold_m) begin
                    md_step = 1'b1;
                    if (md_cnt == CNT_W'(XLEN-1)) md_state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!hold_m) md_state_nxt = MD_IDLE;
            end
            default: md_state_nxt = MD_IDLE;
        endcase
    end

    // Both MUL and DIV run on operand magnitudes; signs are reapplied at the end.
    always_comb begin
        st_is_mul = ~funct3_de[2];
        if (st_is_mul) begin
            st_sa = ((funct3_de == 3'b001) || (funct3_de == 3'b010)) & rf_data1_de[XLEN-1];
            st_sb = (funct3_de == 3'b001) & rf_data2_de[XLEN-1];
        end else begin
            st_sa = ~funct3_de[0] & rf_data1_de[XLEN-1];
            st_sb = ~funct3_de[0] & rf_data2_de[XLEN-1];
        end
        st_mag_a = st_sa ? -rf_data1_de : rf_data1_de;
        st_mag_b = st_sb ? -rf_data2_de : rf_data2_de;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? md_opnd : {XLEN{1'b0}})};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, md_opnd};
        div_diff  = div_shift[XLEN-1:0] - md_opnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt  <= '0;
            md_f3   <= '0;
            md_sa   <= 1'b0;
            md_sb   <= 1'b0;
            md_dz   <= 1'b0;
            md_rd   <= '0;
            md_opnd <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else if (md_start) begin
            md_cnt  <= '0;
            md_f3   <= funct3_de;
            md_sa   <= st_sa;
            md_sb   <= st_sb;
            md_dz   <= rf_data2_de == '0;
            md_rd   <= rd_de;
            md_opnd <= st_is_mul ? st_mag_a : st_mag_b;
            acc_hi  <= '0;
            acc_lo  <= st_is_mul ? st_mag_b : st_mag_a;
        end else if (md_step) begin
            md_cnt <= md_cnt + CNT_W'(1);
            if (!md_f3[2]) begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end else begin
                acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end
        end
    end

    // A zero divisor leaves the dividend magnitude in acc_hi, so only the quotient needs fixing.
    always_comb begin
        prod      = {acc_hi, acc_lo};
        prod_s    = (md_sa ^ md_sb) ? -prod : prod;
        quo_s     = md_dz ? {XLEN{1'b1}} : ((md_sa ^ md_sb) ? -acc_lo : acc_lo);
        rem_s     = md_sa ? -acc_hi : acc_hi;
        md_result = '0;
        case (md_f3)
            3'b000:                 md_result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_result = quo_s;
            default:                md_result = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_em  <= 1'b0;
            result_em <= '0;
            rs2_em    <= '0;
            rd_em     <= '0;
        end else if (!hold_m) begin
            if (md_state == MD_DONE) begin
                valid_em  <= 1'b1;
                result_em <= md_result;
                rs2_em    <= rf_data2_de;
                rd_em     <= md_rd;
            end else if (md_stall) begin
                valid_em <= 1'b0;
            end else begin
                valid_em  <= valid_de;
                result_em <= (jal_de | jalr_de) ? link_pc : alu_y;
                rs2_em    <= rf_data2_de;
                rd_em     <= rd_de;
            end
        end
    end
endmodule
